// File: rtl/bmp_scan_ctrl_if.sv
// Handshake bundle between the bitmap scan controller and its bmpreg / ALU environment.
interface bmp_scan_ctrl_if;
    logic       start;
    logic       abort;
    logic       alustart;
    logic       colready;
    logic       rowtopready;
    logic       rowbotready;
    logic       alu_done;
    logic       alu_match;
    logic       wren;
    logic       nextcol;
    logic       nextrowtop;
    logic       nextrowbot;
    logic       busy;
    logic       done;
    logic       err;
    logic [4:0] col_idx;
    logic [5:0] row_idx;
    logic [6:0] hit_count;

    modport master (
        output start, abort, alustart, colready, rowtopready, rowbotready, alu_done, alu_match,
        input  wren, nextcol, nextrowtop, nextrowbot, busy, done, err, col_idx, row_idx, hit_count
    );

    modport slave (
        input  start, abort, alustart, colready, rowtopready, rowbotready, alu_done, alu_match,
        output wren, nextcol, nextrowtop, nextrowbot, busy, done, err, col_idx, row_idx, hit_count
    );
endinterface

// File: rtl/bmp_scan_ctrl.sv
// Bitmap scan sequencer: loads bmpreg, walks all column slices, then all top/bottom row
// pairs, counting ALU matches; every wait is bounded by a timeout that lands in ERR.
module bmp_scan_ctrl #(
    parameter int NCOL     = 24,
    parameter int NROWPAIR = 32,
    parameter int TIMEOUT  = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    bmp_scan_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_LWAIT,
        S_CREQ,
        S_CWAIT,
        S_CALU,
        S_RREQ,
        S_RWAIT,
        S_RALU,
        S_FIN,
        S_ERR
    } state_t;

    localparam int              WW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WW-1:0]   WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [5:0]      NCOL_U    = 6'(NCOL);
    localparam logic [6:0]      NROW_U    = 7'(NROWPAIR);

    state_t        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          top_q, top_d;
    logic          bot_q, bot_d;
    logic [4:0]    col_q, col_d;
    logic [5:0]    row_q, row_d;
    logic [6:0]    hit_q, hit_d;
    logic          err_q, err_d;
    logic          wren_q, nextcol_q, nextrow_q, busy_q, done_q;

    logic          top_seen, bot_seen, timed_out;
    logic [5:0]    col_inc;
    logic [6:0]    row_inc;

    assign top_seen  = top_q | bus.rowtopready;
    assign bot_seen  = bot_q | bus.rowbotready;
    assign timed_out = (wait_q == WAIT_LAST);
    assign col_inc   = {1'b0, col_q} + 6'd1;
    assign row_inc   = {1'b0, row_q} + 7'd1;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        hit_d   = hit_q;
        err_d   = err_q;
        top_d   = 1'b0;
        bot_d   = 1'b0;
        wait_d  = '0;

        case (state_q)
            S_IDLE, S_ERR: begin
                if (bus.start) begin
                    col_d   = '0;
                    row_d   = '0;
                    hit_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: state_d = S_LWAIT;
            S_LWAIT: begin
                if (bus.alustart)   state_d = S_CREQ;
                else if (timed_out) state_d = S_ERR;
            end
            S_CREQ: state_d = S_CWAIT;
            S_CWAIT: begin
                if (bus.colready)   state_d = S_CALU;
                else if (timed_out) state_d = S_ERR;
            end
            S_CALU: begin
                if (bus.alu_done) begin
                    col_d   = col_inc[4:0];
                    hit_d   = hit_q + {6'd0, bus.alu_match};
                    state_d = (col_inc < NCOL_U) ? S_CREQ : S_RREQ;
                end else if (timed_out) begin
                    state_d = S_ERR;
                end
            end
            S_RREQ: state_d = S_RWAIT;
            S_RWAIT: begin
                // Top and bottom readies may arrive in any order; hold each until both are seen.
                if (top_seen && bot_seen) begin
                    state_d = S_RALU;
                end else if (timed_out) begin
                    state_d = S_ERR;
                end else begin
                    top_d = top_seen;
                    bot_d = bot_seen;
                end
            end
            S_RALU: begin
                if (bus.alu_done) begin
                    row_d   = row_inc[5:0];
                    hit_d   = hit_q + {6'd0, bus.alu_match};
                    state_d = (row_inc < NROW_U) ? S_RREQ : S_FIN;
                end else if (timed_out) begin
                    state_d = S_ERR;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_ERR) err_d = 1'b1;

        // Abort overrides everything decided above, freezing the progress counters.
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            col_d   = col_q;
            row_d   = row_q;
            hit_d   = hit_q;
            err_d   = err_q;
            top_d   = 1'b0;
            bot_d   = 1'b0;
        end

        if ((state_d == state_q) &&
            (state_q inside {S_LWAIT, S_CWAIT, S_CALU, S_RWAIT, S_RALU}))
            wait_d = wait_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            top_q     <= 1'b0;
            bot_q     <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            hit_q     <= '0;
            err_q     <= 1'b0;
            wren_q    <= 1'b0;
            nextcol_q <= 1'b0;
            nextrow_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            top_q     <= top_d;
            bot_q     <= bot_d;
            col_q     <= col_d;
            row_q     <= row_d;
            hit_q     <= hit_d;
            err_q     <= err_d;
            wren_q    <= (state_d == S_LOAD);
            nextcol_q <= (state_d == S_CREQ);
            nextrow_q <= (state_d == S_RREQ);
            busy_q    <= (state_d inside {S_LOAD, S_LWAIT, S_CREQ, S_CWAIT, S_CALU,
                                          S_RREQ, S_RWAIT, S_RALU});
            done_q    <= (state_d == S_FIN);
        end
    end

    assign bus.wren       = wren_q;
    assign bus.nextcol    = nextcol_q;
    assign bus.nextrowtop = nextrow_q;
    assign bus.nextrowbot = nextrow_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.col_idx    = col_q;
    assign bus.row_idx    = row_q;
    assign bus.hit_count  = hit_q;
endmodule

// File: tb/tb_bmp_scan_ctrl.sv
// Directed bench for bmp_scan_ctrl: a latency-programmable bmpreg/ALU responder plus
// scenario-level checks of strobe counts, indices, match counts and error/abort/reset paths.
module tb_bmp_scan_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bmp_scan_ctrl_if bus ();

    bmp_scan_ctrl #(
        .NCOL    (24),
        .NROWPAIR(32),
        .TIMEOUT (15)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Responder configuration, set by the scenario sequencer.
    int top_lat   = 2;
    int bot_lat   = 2;
    int drop_col  = -1;
    int abort_row = -1;
    bit spur_en   = 1'b0;

    // Observation counters and timestamps, owned by the responder process.
    int cyc = 0, n_wren = 0, n_col = 0, n_rt = 0, n_rb = 0, n_done = 0;
    int n_unpaired = 0, n_back2back = 0, n_done_busy = 0;
    int last_rt_cyc = -1, gap_min = 1000, gap_max = 0, gap = 0;
    int last_col_cyc = -1, err_cyc = -1, abort_cyc = -1, idle_cyc = -1;
    bit strobe_now = 1'b0, strobe_prev = 1'b0;

    int cd_load = -1, cd_col = -1, cd_top = -1, cd_bot = -1, cd_alu = -1, cd_spur = -1, cd_abort = -1;
    bit got_top = 1'b0, got_bot = 1'b0, row_pend = 1'b0;
    int ncol_req = 0, nrow_req = 0, slice = 0;

    // Scenario baselines, owned by the sequencer.
    int b_wren, b_col, b_rt, b_rb, b_done, b_unpaired, b_back2back, b_done_busy;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int outs_vec();
        logic [31:0] v;
        v = {7'd0, bus.wren, bus.nextcol, bus.nextrowtop, bus.nextrowbot, bus.busy, bus.done,
             bus.err, bus.col_idx, bus.row_idx, bus.hit_count};
        return int'(v);
    endfunction

    always @(negedge clk) begin
        cyc++;
        strobe_now = bus.wren | bus.nextcol | bus.nextrowtop | bus.nextrowbot;
        if (strobe_now && strobe_prev) n_back2back++;
        strobe_prev = strobe_now;
        if (bus.wren) n_wren++;
        if (bus.nextcol) begin
            n_col++;
            last_col_cyc = cyc;
        end
        if (bus.nextrowtop) begin
            n_rt++;
            if (last_rt_cyc >= 0) begin
                gap = cyc - last_rt_cyc;
                if (gap < gap_min) gap_min = gap;
                if (gap > gap_max) gap_max = gap;
            end
            last_rt_cyc = cyc;
        end
        if (bus.nextrowbot) n_rb++;
        if (bus.nextrowtop != bus.nextrowbot) n_unpaired++;
        if (bus.done) begin
            n_done++;
            if (bus.busy) n_done_busy++;
        end
        if (bus.err && err_cyc < 0) err_cyc = cyc;
        if (abort_cyc >= 0 && idle_cyc < 0 && !bus.busy) idle_cyc = cyc;

        bus.alustart    = 1'b0;
        bus.colready    = 1'b0;
        bus.rowtopready = 1'b0;
        bus.rowbotready = 1'b0;
        bus.alu_done    = 1'b0;
        bus.alu_match   = 1'b0;
        bus.abort       = 1'b0;

        if (!rst_n) begin
            cd_load = -1; cd_col = -1; cd_top = -1; cd_bot = -1;
            cd_alu = -1; cd_spur = -1; cd_abort = -1;
            got_top = 1'b0; got_bot = 1'b0; row_pend = 1'b0;
        end else begin
            // Countdowns fire first; new requests seen this cycle arm afterwards.
            if (cd_spur > 0 && --cd_spur == 0) begin
                bus.alu_done = 1'b1; bus.alu_match = 1'b1; cd_spur = -1;
            end
            if (cd_alu > 0 && --cd_alu == 0) begin
                bus.alu_done = 1'b1; bus.alu_match = (slice % 2) == 1; slice++; cd_alu = -1;
            end
            if (cd_load > 0 && --cd_load == 0) begin
                bus.alustart = 1'b1; cd_load = -1;
            end
            if (cd_abort > 0 && --cd_abort == 0) begin
                bus.abort = 1'b1; abort_cyc = cyc; cd_abort = -1;
            end
            if (cd_col > 0 && --cd_col == 0) begin
                bus.colready = 1'b1; cd_alu = 2; cd_col = -1;
            end
            if (cd_top > 0 && --cd_top == 0) begin
                bus.rowtopready = 1'b1; got_top = 1'b1; cd_top = -1;
                if (spur_en && !got_bot) cd_spur = 1;
            end
            if (cd_bot > 0 && --cd_bot == 0) begin
                bus.rowbotready = 1'b1; got_bot = 1'b1; cd_bot = -1;
            end
            if (row_pend && got_top && got_bot) begin
                cd_alu = 2; row_pend = 1'b0;
            end

            if (bus.wren) begin
                cd_load = 1; cd_col = -1; cd_top = -1; cd_bot = -1; cd_alu = -1;
                cd_spur = -1; cd_abort = -1;
                ncol_req = 0; nrow_req = 0; slice = 0;
                last_rt_cyc = -1; gap_min = 1000; gap_max = 0;
                err_cyc = -1; abort_cyc = -1; idle_cyc = -1;
            end
            if (bus.nextcol) begin
                if (ncol_req != drop_col) cd_col = 2;
                ncol_req++;
            end
            if (bus.nextrowtop) begin
                if (nrow_req == abort_row) begin
                    cd_abort = 1;
                end else begin
                    cd_top = top_lat; cd_bot = bot_lat;
                    got_top = 1'b0; got_bot = 1'b0; row_pend = 1'b1;
                end
                nrow_req++;
            end
        end
    end

    task automatic snap();
        b_wren = n_wren; b_col = n_col; b_rt = n_rt; b_rb = n_rb; b_done = n_done;
        b_unpaired = n_unpaired; b_back2back = n_back2back; b_done_busy = n_done_busy;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int k = 0;
        while (!bus.done && k < limit) begin
            @(negedge clk);
            k++;
        end
        check_val(tag, int'(bus.done), 1);
    endtask

    task automatic check_scan(input string tag, input int ncols, input int nrows, input int hits);
        check_val({tag, "_wren"},     n_wren - b_wren, 1);
        check_val({tag, "_nextcol"},  n_col - b_col, ncols);
        check_val({tag, "_nrowtop"},  n_rt - b_rt, nrows);
        check_val({tag, "_nrowbot"},  n_rb - b_rb, nrows);
        check_val({tag, "_ndone"},    n_done - b_done, 1);
        check_val({tag, "_unpaired"}, n_unpaired - b_unpaired, 0);
        check_val({tag, "_b2b"},      n_back2back - b_back2back, 0);
        check_val({tag, "_donebusy"}, n_done_busy - b_done_busy, 0);
        check_val({tag, "_col_idx"},  int'(bus.col_idx), 24);
        check_val({tag, "_row_idx"},  int'(bus.row_idx), 32);
        check_val({tag, "_hits"},     int'(bus.hit_count), hits);
        check_val({tag, "_busy"},     int'(bus.busy), 0);
        check_val({tag, "_err"},      int'(bus.err), 0);
    endtask

    initial begin
        int k;
        bus.start = 1'b0;

        #12;
        check_val("rst_outputs", outs_vec(), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_val("idle_busy", int'(bus.busy), 0);

        // Full scan with nominal latencies.
        snap();
        pulse_start();
        check_val("s1_wren_lat", int'(bus.wren), 1);
        check_val("s1_busy", int'(bus.busy), 1);
        wait_done("s1_done", 2000);
        repeat (2) @(negedge clk);
        check_scan("s1", 24, 32, 28);
        check_val("s1_rowgap", gap_max, 5);
        repeat (5) @(negedge clk);
        check_val("s1_hold_hits", int'(bus.hit_count), 28);

        // Skewed row readies with a stray alu_done while still waiting for the bottom slice.
        top_lat = 1; bot_lat = 4; spur_en = 1'b1;
        snap();
        pulse_start();
        wait_done("s2_done", 2000);
        repeat (2) @(negedge clk);
        check_scan("s2", 24, 32, 28);
        check_val("s2_gap_min", gap_min, 7);
        check_val("s2_gap_max", gap_max, 7);
        top_lat = 2; bot_lat = 2; spur_en = 1'b0;

        // Abort during RWAIT of row pair 10, with an ignored start mid-scan.
        abort_row = 10;
        snap();
        pulse_start();
        repeat (20) @(negedge clk);
        pulse_start();
        k = 0;
        while (bus.busy && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check_val("s3_idle", int'(bus.busy), 0);
        repeat (3) @(negedge clk);
        check_val("s3_abort_lat", idle_cyc - abort_cyc, 1);
        check_val("s3_ndone", n_done - b_done, 0);
        check_val("s3_wren", n_wren - b_wren, 1);
        check_val("s3_nrowtop", n_rt - b_rt, 11);
        check_val("s3_row_idx", int'(bus.row_idx), 10);
        check_val("s3_col_idx", int'(bus.col_idx), 24);
        check_val("s3_hits", int'(bus.hit_count), 17);
        check_val("s3_err", int'(bus.err), 0);
        abort_row = -1;

        // Column 5 never becomes ready: timeout into ERR, then recovery.
        drop_col = 5;
        snap();
        pulse_start();
        k = 0;
        while (!bus.err && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check_val("s4_err", int'(bus.err), 1);
        repeat (3) @(negedge clk);
        check_val("s4_to_lat", err_cyc - last_col_cyc, 16);
        check_val("s4_busy", int'(bus.busy), 0);
        check_val("s4_err_sticky", int'(bus.err), 1);
        check_val("s4_col_idx", int'(bus.col_idx), 5);
        check_val("s4_hits", int'(bus.hit_count), 2);
        check_val("s4_nextcol", n_col - b_col, 6);
        check_val("s4_ndone", n_done - b_done, 0);
        drop_col = -1;
        snap();
        pulse_start();
        check_val("s4r_err_clr", int'(bus.err), 0);
        wait_done("s4r_done", 2000);
        repeat (2) @(negedge clk);
        check_scan("s4r", 24, 32, 28);

        // Asynchronous reset while in CALU of column 2.
        pulse_start();
        repeat (15) @(negedge clk);
        check_val("s5_pre_col", int'(bus.col_idx), 2);
        check_val("s5_pre_hits", int'(bus.hit_count), 1);
        #1 rst_n = 1'b0;
        #1;
        check_val("s5_rst_outs", outs_vec(), 0);
        repeat (2) @(negedge clk);
        snap();
        bus.start = 1'b1;
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_val("s5_first_edge", int'(bus.wren), 1);
        bus.start = 1'b0;
        wait_done("s5_done", 2000);
        repeat (2) @(negedge clk);
        check_scan("s5", 24, 32, 28);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bmp_scan_ctrl.md
BMP_SCAN_CTRL -- requirements
Module: bmp_scan_ctrl

Interface
REQ-001 SHALL have parameters: NCOL, 24, column slices per bitmap; NROWPAIR, 32, top/bottom row-slice pairs per bitmap; TIMEOUT, 15, maximum wait cycles for any ready or done input.
REQ-002 SHALL have ports, all outputs registered (name  direction  width  meaning):
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request scan of the bitmap on bmpreg input
- abort  in  1  cancel the scan in progress
- alustart  in  1  bmpreg load acknowledge
- colready  in  1  bmpreg column slice valid
- rowtopready  in  1  bmpreg top row slice valid
- rowbotready  in  1  bmpreg bottom row slice valid
- alu_done  in  1  ALU finished current slice
- alu_match  in  1  ALU result for current slice, valid with alu_done
- wren  out  1  bmpreg load strobe
- nextcol  out  1  column advance strobe
- nextrowtop  out  1  top row advance strobe
- nextrowbot  out  1  bottom row advance strobe
- busy  out  1  scan in progress
- done  out  1  scan complete pulse
- err  out  1  timeout error, sticky
- col_idx  out  5  column slices completed
- row_idx  out  6  row pairs completed
- hit_count  out  7  alu_match count for current scan

Function
REQ-003 SHALL implement states IDLE, LOAD, LWAIT, CREQ, CWAIT, CALU, RREQ, RWAIT, RALU, FIN, ERR.
REQ-004 IDLE: start=1 SHALL clear col_idx, row_idx, hit_count and err and go to LOAD; busy=1 from LOAD through RALU.
REQ-005 LOAD SHALL assert wren for exactly one cycle, then go to LWAIT.
REQ-006 LWAIT SHALL go to CREQ on alustart=1.
REQ-007 CREQ SHALL assert nextcol for exactly one cycle, then go to CWAIT; CWAIT SHALL go to CALU on colready=1.
REQ-008 CALU on alu_done=1: SHALL increment col_idx, add alu_match to hit_count, then go to CREQ if col_idx+1 < NCOL, otherwise to RREQ.
REQ-009 RREQ SHALL assert nextrowtop and nextrowbot together for exactly one cycle, then go to RWAIT.
REQ-010 RWAIT SHALL latch rowtopready and rowbotready independently and go to RALU in the cycle both are latched, whether they arrive in the same or different cycles; both latches clear on RALU entry.
REQ-011 RALU on alu_done=1: SHALL increment row_idx, add alu_match to hit_count, then go to RREQ if row_idx+1 < NROWPAIR, otherwise to FIN.
REQ-012 FIN SHALL assert done for exactly one cycle with busy=0, then return to IDLE; col_idx, row_idx and hit_count hold until the next start.
REQ-013 No more than one advance strobe group SHALL be outstanding; strobes SHALL never be asserted in wait states.
REQ-014 A wait counter SHALL clear on entry to LWAIT, CWAIT, CALU, RWAIT or RALU and increment each cycle in the state; reaching TIMEOUT without the awaited input SHALL go to ERR.
REQ-015 ERR SHALL hold err=1 and busy=0 and stay until start=1, which behaves as in REQ-004.
REQ-016 abort=1 in any state other than IDLE SHALL go to IDLE next cycle with no done, counters held, err unchanged; abort SHALL take priority over every other transition.
REQ-017 start while busy or in FIN SHALL be ignored.
REQ-018 alu_done outside CALU/RALU and ready inputs outside their wait states SHALL be ignored.
REQ-019 hit_count SHALL not wrap: max NCOL+NROWPAIR = 56 < 128.

Reset
REQ-020 rst_n=0 SHALL asynchronously force IDLE and all outputs, counters, latches and wait counter to 0, including mid-scan.
REQ-021 The first state transition SHALL occur on the first rising clk edge after rst_n deasserts.

Verification
REQ-022 Full scan: start, alustart 1 cycle after wren, every ready and alu_done 2 cycles after request, alu_match=1 on odd slices -> 24 nextcol pulses, 32 paired row pulses, done once, hit_count=28, col_idx=24, row_idx=32.
REQ-023 Skewed readies: rowtopready 1 cycle, rowbotready 4 cycles after RREQ -> RALU entered only after rowbotready; no extra strobes.
REQ-024 Timeout: colready never asserted on column 5 -> ERR after 15 CWAIT cycles, err=1, busy=0, col_idx=5; next start clears err and rescans.
REQ-025 Abort: abort during RWAIT of row pair 10 -> IDLE next cycle, no done, row_idx=10; start pulsed during scan is ignored.
REQ-026 Reset mid-scan: rst_n=0 asynchronously in CALU -> all outputs 0 before next clk edge; scan restarts cleanly after release.
